// File: rtl/cndm_micro_txq_sched.sv
// rtl/cndm_micro_txq_sched.sv - round-robin TX queue scheduler issuing descriptor-fetch requests
module cndm_micro_txq_sched #(
    parameter int QUEUES       = 4,
    parameter int PTR_W        = 16,
    parameter int MAX_INFLIGHT = 4,
    localparam int QN_W        = (QUEUES > 1) ? $clog2(QUEUES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sched_en,
    input  logic [QUEUES-1:0]       q_en,
    input  logic [QUEUES*PTR_W-1:0] q_prod,
    output logic [QUEUES*PTR_W-1:0] q_cons,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [QN_W-1:0]         req_queue,
    output logic [PTR_W-1:0]        req_index,
    input  logic                    done,
    output logic [7:0]              inflight,
    output logic                    busy,
    output logic                    err_underflow
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]       state;
    logic [QN_W-1:0]  rr;
    logic [PTR_W-1:0] prod [QUEUES];
    logic [PTR_W-1:0] cons [QUEUES];
    logic [QUEUES-1:0] eligible;
    logic             grant_found;
    logic [QN_W-1:0]  grant_q;
    logic             accept;
    logic             can_issue;

    assign accept    = req_valid && req_ready;
    assign can_issue = sched_en && (inflight < 8'(MAX_INFLIGHT)) && grant_found;
    assign busy      = req_valid || (inflight != 8'd0);

    for (genvar g = 0; g < QUEUES; g++) begin : g_pack
        assign q_cons[g*PTR_W +: PTR_W] = cons[g];
    end

    always_comb begin
        for (int i = 0; i < QUEUES; i++) begin
            prod[i]     = q_prod[i*PTR_W +: PTR_W];
            eligible[i] = q_en[i] && (prod[i] != cons[i]);
        end
    end

    // Search from rr+QUEUES down to rr+1 so the closest eligible queue after rr is the last writer.
    always_comb begin
        int j;
        j           = 0;
        grant_found = 1'b0;
        grant_q     = '0;
        for (int k = QUEUES; k >= 1; k--) begin
            j = (int'(rr) + k) % QUEUES;
            if (eligible[j]) begin
                grant_found = 1'b1;
                grant_q     = QN_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            req_valid     <= 1'b0;
            req_queue     <= '0;
            req_index     <= '0;
            rr            <= QN_W'(QUEUES - 1);
            inflight      <= 8'd0;
            err_underflow <= 1'b0;
            for (int i = 0; i < QUEUES; i++) begin
                cons[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (can_issue) begin
                        state     <= ST_ISSUE;
                        req_valid <= 1'b1;
                        req_queue <= grant_q;
                        req_index <= cons[grant_q];
                    end
                end
                ST_ISSUE: begin
                    if (accept) begin
                        state     <= ST_IDLE;
                        req_valid <= 1'b0;
                        rr        <= req_queue;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_valid <= 1'b0;
                end
            endcase

            // A same-cycle accept supplies the credit that the done returns, so it is not an underflow.
            if (accept && !done) begin
                inflight <= inflight + 8'd1;
            end else if (done && !accept) begin
                if (inflight != 8'd0) begin
                    inflight <= inflight - 8'd1;
                end else begin
                    err_underflow <= 1'b1;
                end
            end

            for (int i = 0; i < QUEUES; i++) begin
                if (!q_en[i]) begin
                    cons[i] <= prod[i];
                end else if (accept && (req_queue == QN_W'(i))) begin
                    cons[i] <= cons[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cndm_micro_txq_sched.sv
// tb/tb_cndm_micro_txq_sched.sv - directed bench with transaction-level reference model
module tb_cndm_micro_txq_sched;

    localparam int Q  = 4;
    localparam int PW = 16;
    localparam int MI = 4;
    localparam int QW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            sched_en;
    logic [Q-1:0]    q_en;
    logic [Q*PW-1:0] q_prod;
    logic [Q*PW-1:0] q_cons;
    logic            req_valid;
    logic            req_ready;
    logic [QW-1:0]   req_queue;
    logic [PW-1:0]   req_index;
    logic            done;
    logic [7:0]      inflight;
    logic            busy;
    logic            err_underflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit will_acc = 1'b0;
    bit auto_done = 1'b0;
    int log_q[$];
    int log_i[$];
    int log_t[$];

    bit m_valid;
    int m_q, m_idx, m_infl, m_rr;
    bit m_err;
    int m_cons[Q];

    cndm_micro_txq_sched #(.QUEUES(Q), .PTR_W(PW), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .q_en(q_en), .q_prod(q_prod),
        .q_cons(q_cons), .req_valid(req_valid), .req_ready(req_ready), .req_queue(req_queue),
        .req_index(req_index), .done(done), .inflight(inflight), .busy(busy),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int prod_of(input int i);
        return int'(q_prod[i*PW +: PW]);
    endfunction

    function automatic int cons_of(input int i);
        return int'(q_cons[i*PW +: PW]);
    endfunction

    // Reference: a request is outstanding until handshaken; a new grant needs no pending request,
    // a free credit and some enabled queue with unconsumed entries, searched after the last winner.
    always @(posedge clk or negedge rst_n) begin : model
        bit acc;
        int j, pick;
        int nc[Q];
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_q     <= 0;
            m_idx   <= 0;
            m_infl  <= 0;
            m_err   <= 1'b0;
            m_rr    <= Q - 1;
            for (int i = 0; i < Q; i++) m_cons[i] <= 0;
        end else begin
            acc  = m_valid && req_ready;
            pick = -1;
            if (!m_valid && sched_en && m_infl < MI) begin
                for (int k = 1; k <= Q; k++) begin
                    j = (m_rr + k) % Q;
                    if (pick < 0 && q_en[j] && prod_of(j) != m_cons[j]) pick = j;
                end
            end
            for (int i = 0; i < Q; i++) begin
                nc[i] = m_cons[i];
                if (acc && i == m_q) nc[i] = (nc[i] + 1) % 65536;
                if (!q_en[i]) nc[i] = prod_of(i);
                m_cons[i] <= nc[i];
            end
            if (acc) begin
                m_valid <= 1'b0;
                m_rr    <= m_q;
            end
            if (pick >= 0) begin
                m_valid <= 1'b1;
                m_q     <= pick;
                m_idx   <= m_cons[pick];
            end
            if (acc && !done) m_infl <= m_infl + 1;
            else if (done && !acc) begin
                if (m_infl > 0) m_infl <= m_infl - 1;
                else m_err <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("req_valid", int'(req_valid), int'(m_valid));
        if (m_valid) begin
            chk("req_queue", int'(req_queue), m_q);
            chk("req_index", int'(req_index), m_idx);
        end
        for (int i = 0; i < Q; i++) chk("q_cons", cons_of(i), m_cons[i]);
        chk("inflight", int'(inflight), m_infl);
        chk("busy", int'(busy), int'(m_valid || m_infl != 0));
        chk("err_underflow", int'(err_underflow), int'(m_err));
        will_acc = req_valid && req_ready;
        if (will_acc) begin
            log_q.push_back(int'(req_queue));
            log_i.push_back(int'(req_index));
            log_t.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        done = auto_done && will_acc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sched_en = 1'b0; q_en = '0; q_prod = '0; req_ready = 1'b0;
        auto_done = 1'b0; done = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        log_q.delete(); log_i.delete(); log_t.delete();
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!req_valid && n < 20) begin
            tick();
            n++;
        end
        chk(name, int'(req_valid), 1);
    endtask

    initial begin
        int exp_rr[8];
        exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
        sched_en = 1'b0; q_en = '0; q_prod = '0; req_ready = 1'b0; done = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req_valid", int'(req_valid), 0);
        chk("rst_req_queue", int'(req_queue), 0);
        chk("rst_req_index", int'(req_index), 0);
        chk("rst_inflight", int'(inflight), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err_underflow), 0);
        chk("rst_q_cons", int'(q_cons == '0), 1);
        do_reset();

        // single queue, three entries
        q_en = 4'b0001; q_prod[0 +: PW] = 16'd3; req_ready = 1'b1; sched_en = 1'b1; auto_done = 1'b1;
        repeat (20) tick();
        chk("t1_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t1_queue", log_q[i], 0);
                chk("t1_index", log_i[i], i);
            end
            chk("t1_spacing", log_t[1] - log_t[0], 2);
            chk("t1_spacing", log_t[2] - log_t[1], 2);
        end
        chk("t1_cons", cons_of(0), 3);
        chk("t1_busy", int'(busy), 0);

        // round robin across all queues
        do_reset();
        q_en = 4'hF; q_prod = {16'd2, 16'd2, 16'd2, 16'd2};
        req_ready = 1'b1; sched_en = 1'b1; auto_done = 1'b1;
        repeat (30) tick();
        chk("t2_count", log_q.size(), 8);
        if (log_q.size() == 8)
            for (int i = 0; i < 8; i++) chk("t2_queue", log_q[i], exp_rr[i]);
        for (int i = 0; i < Q; i++) chk("t2_cons", cons_of(i), 2);

        // credit limit
        do_reset();
        q_en = 4'b0001; q_prod[0 +: PW] = 16'd10; req_ready = 1'b1; sched_en = 1'b1;
        repeat (20) tick();
        chk("t3_count_stall", log_q.size(), 4);
        chk("t3_inflight", int'(inflight), 4);
        chk("t3_valid_stall", int'(req_valid), 0);
        done = 1'b1;
        tick();
        repeat (10) tick();
        chk("t3_count_after_done", log_q.size(), 5);
        chk("t3_inflight_after", int'(inflight), 4);

        // pointer wrap
        do_reset();
        q_prod[0 +: PW] = 16'hFFFE; sched_en = 1'b1;
        repeat (2) tick();
        chk("t4_flush_cons", cons_of(0), 16'hFFFE);
        q_prod[0 +: PW] = 16'h0001; q_en = 4'b0001; req_ready = 1'b1; auto_done = 1'b1;
        repeat (15) tick();
        chk("t4_count", log_q.size(), 3);
        if (log_i.size() == 3) begin
            chk("t4_idx0", log_i[0], 16'hFFFE);
            chk("t4_idx1", log_i[1], 16'hFFFF);
            chk("t4_idx2", log_i[2], 16'h0000);
        end
        chk("t4_cons", cons_of(0), 1);

        // backpressure with flush of the pending queue
        do_reset();
        q_en = 4'b0010; q_prod[PW +: PW] = 16'd5; sched_en = 1'b1;
        repeat (3) tick();
        chk("t5_valid", int'(req_valid), 1);
        chk("t5_queue", int'(req_queue), 1);
        chk("t5_index", int'(req_index), 0);
        q_en = 4'b0000;
        repeat (3) tick();
        chk("t5_held_valid", int'(req_valid), 1);
        chk("t5_held_queue", int'(req_queue), 1);
        chk("t5_held_index", int'(req_index), 0);
        chk("t5_flush_cons", cons_of(1), 5);
        req_ready = 1'b1;
        repeat (6) tick();
        chk("t5_count", log_q.size(), 1);
        chk("t5_cons_after", cons_of(1), 5);
        chk("t5_inflight", int'(inflight), 1);
        q_prod[0 +: PW] = 16'd1; q_en = 4'b0001;
        wait_valid("t5_wait_valid");
        done = 1'b1;
        tick();
        chk("t5_acc_done_inflight", int'(inflight), 1);
        chk("t5_count2", log_q.size(), 2);
        chk("t5_cons0", cons_of(0), 1);

        // underflow then asynchronous reset during a pending request
        do_reset();
        done = 1'b1;
        tick();
        chk("t6_err", int'(err_underflow), 1);
        chk("t6_inflight", int'(inflight), 0);
        q_en = 4'b0001; q_prod[0 +: PW] = 16'd2; sched_en = 1'b1;
        wait_valid("t6_wait_valid");
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(req_valid), 0);
        chk("t6_rst_err", int'(err_underflow), 0);
        chk("t6_rst_cons", cons_of(0), 0);
        chk("t6_rst_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        q_en = '0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
